ram_1r1w_clear: RTL and testbench

//   Parametrised 1-read/1-write synchronous SRAM macro model, byte-lane write enables.

---
 rtl/ram_pkg.sv | 20 ++
 rtl/ram_clear_fsm.sv | 69 ++++++
 rtl/ram_1r1w_clear.sv | 104 ++++++++++
 tb/tb_ram_1r1w_clear.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared definitions for the 1R1W byte-write RAM model.
//   lanes()     : number of byte lanes for a given data width
//   ram_state_e : zero-fill controller states
//   CLR_LANE    : data written into every byte lane during the zero-fill
package ram_pkg;

    // WIDTH is expected to be a multiple of 8; any remainder bits are not
    // covered by a lane enable.
    function automatic int lanes(input int width);
        return width / 8;
    endfunction

    typedef enum logic {
        INIT = 1'b0,
        DONE = 1'b1
    } ram_state_e;

    localparam logic [7:0] CLR_LANE = 8'h00;

endpackage

// File: rtl/ram_clear_fsm.sv
// ram_clear_fsm: post-reset zero-fill sequencer for ram_1r1w_clear.
//   Walks every word address once after reset and then raises o_rdy.
// Parameters
//   BITS  : address width (2**BITS words to clear)
//   CLEAR : 1 = run the fill, 0 = go straight to DONE
// Ports
//   i_clk      : clock, posedge
//   i_rst      : synchronous active-high reset
//   o_rdy      : 1 once the fill has finished (registered)
//   o_clr_we   : clear-write strobe, one word per cycle while filling
//   o_clr_addr : word address for the clear write
module ram_clear_fsm
    import ram_pkg::*;
#(
    parameter int BITS  = 9,
    parameter int CLEAR = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_rdy,
    output logic            o_clr_we,
    output logic [BITS-1:0] o_clr_addr
);

    ram_state_e      r_state;
    ram_state_e      w_state_nxt;
    logic [BITS-1:0] r_cnt;
    logic [BITS-1:0] w_cnt_nxt;
    logic            r_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= (CLEAR != 0) ? INIT : DONE;
            r_cnt   <= '0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            // Registered so RDY is low during reset even when no fill runs,
            // and rises on the same edge that writes the last word.
            r_rdy   <= (w_state_nxt == DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clr_we    = 1'b0;
        case (r_state)
            INIT: begin
                // No clear write on a reset edge; the fill restarts from 0.
                o_clr_we  = ~i_rst;
                w_cnt_nxt = r_cnt + BITS'(1);
                if (&r_cnt)
                    w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = DONE;
            end
            default: begin
                w_state_nxt = DONE;
            end
        endcase
    end

    assign o_rdy      = r_rdy;
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/ram_1r1w_clear.sv
// ram_1r1w_clear: 1-read / 1-write synchronous SRAM model with byte-lane
// write enables, write-first collision forwarding and post-reset zero-fill.
// Parameters
//   BITS  : address width, depth = 2**BITS words
//   WIDTH : data width, multiple of 8 (LANES = WIDTH/8)
//   CLEAR : 1 = zero-fill after reset, 0 = ready one cycle after reset
// Build option
//   RAM_OUTREG_EN : adds an output register, read latency becomes 2
// Ports
//   CLK : clock          RST : synchronous active-high reset
//   RDY : init complete, ports accepted
//   EN0 : read enable    A0  : read address    Do0 : read data
//   WE1 : byte-lane write enables   A1 : write address   Di1 : write data
module ram_1r1w_clear
    import ram_pkg::*;
#(
    parameter int BITS  = 9,
    parameter int WIDTH = 64,
    parameter int CLEAR = 1
) (
    input  logic                    CLK,
    input  logic                    RST,
    output logic                    RDY,
    input  logic                    EN0,
    input  logic [BITS-1:0]         A0,
    output logic [WIDTH-1:0]        Do0,
    input  logic [lanes(WIDTH)-1:0] WE1,
    input  logic [BITS-1:0]         A1,
    input  logic [WIDTH-1:0]        Di1
);

    localparam int LANES = lanes(WIDTH);
    localparam int DEPTH = 1 << BITS;

    logic             w_rdy;
    logic             w_clr_we;
    logic [BITS-1:0]  w_clr_addr;

    logic [LANES-1:0] w_we;
    logic [BITS-1:0]  w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic             w_coll;
    logic [WIDTH-1:0] w_rd_word;
    logic [WIDTH-1:0] r_rd_s1;

    ram_clear_fsm #(
        .BITS  (BITS),
        .CLEAR (CLEAR)
    ) u_clear (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_rdy      (w_rdy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // Write port belongs to the fill sequencer until RDY, then to the user.
    assign w_we    = w_rdy ? WE1 : {LANES{w_clr_we}};
    assign w_waddr = w_rdy ? A1  : w_clr_addr;
    assign w_wdata = w_rdy ? Di1 : {LANES{CLR_LANE}};

    // Same-edge read and write of one word: written lanes are forwarded.
    assign w_coll  = EN0 & (|WE1) & (A0 == A1);

    // The word array is held as one 8-bit bank per lane so each bank has a
    // single plain write enable, which maps onto byte-write SRAM.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] r_mem [0:DEPTH-1];

        always_ff @(posedge CLK) begin
            if (w_we[l])
                r_mem[w_waddr] <= w_wdata[l*8 +: 8];
        end

        assign w_rd_word[l*8 +: 8] = (w_coll & WE1[l]) ? Di1[l*8 +: 8]
                                                      : r_mem[A0];
    end

    // Read stage 1: a disabled or not-ready read returns zero.
    always_ff @(posedge CLK) begin
        if (RST)
            r_rd_s1 <= '0;
        else
            r_rd_s1 <= (w_rdy & EN0) ? w_rd_word : '0;
    end

`ifdef RAM_OUTREG_EN
    logic [WIDTH-1:0] r_rd_s2;

    always_ff @(posedge CLK) begin
        if (RST)
            r_rd_s2 <= '0;
        else
            r_rd_s2 <= r_rd_s1;
    end

    assign Do0 = r_rd_s2;
`else
    assign Do0 = r_rd_s1;
`endif

    assign RDY = w_rdy;

endmodule

// File: tb/tb_ram_1r1w_clear.sv
module tb_ram_1r1w_clear;

`ifdef RAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        RDY;
    logic        EN0 = 1'b0;
    logic [3:0]  A0 = '0;
    logic [31:0] Do0;
    logic [3:0]  WE1 = '0;
    logic [3:0]  A1 = '0;
    logic [31:0] Di1 = '0;

    logic        RST_0 = 1'b1;
    logic        RDY_0;
    logic        EN0_0 = 1'b0;
    logic [3:0]  A0_0 = '0;
    logic [31:0] Do0_0;
    logic [3:0]  WE1_0 = '0;
    logic [3:0]  A1_0 = '0;
    logic [31:0] Di1_0 = '0;

    int total = 0;
    int bad   = 0;

    logic        chk_req = 1'b0;
    logic [1:0]  vld_pipe = '0;
    logic [31:0] exp_q[$];
    int          id_q[$];
    int          rd_id = 0;

    always #5 CLK = ~CLK;

    ram_1r1w_clear #(.BITS(4), .WIDTH(32), .CLEAR(1)) dut (
        .CLK(CLK), .RST(RST), .RDY(RDY), .EN0(EN0), .A0(A0), .Do0(Do0),
        .WE1(WE1), .A1(A1), .Di1(Di1)
    );

    ram_1r1w_clear #(.BITS(4), .WIDTH(32), .CLEAR(0)) dut0 (
        .CLK(CLK), .RST(RST_0), .RDY(RDY_0), .EN0(EN0_0), .A0(A0_0), .Do0(Do0_0),
        .WE1(WE1_0), .A1(A1_0), .Di1(Di1_0)
    );

    // Tracks which cycles carry a checked read, delayed to the read latency.
    always @(posedge CLK) vld_pipe <= {vld_pipe[0], chk_req};

    // Monitor: pops and compares whenever a checked read reaches Do0.
    always @(negedge CLK) begin
        if (vld_pipe[LAT-1]) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_underflow act=%h exp=<queued value>", Do0);
            end else begin
                logic [31:0] e;
                int          id;
                e  = exp_q.pop_front();
                id = id_q.pop_front();
                if (Do0 !== e) begin
                    bad++;
                    $display("FAIL rd%0d act=%h exp=%h", id, Do0, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        total++;
        if (act !== ex) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, ex);
        end
    endtask

    // One cycle of port activity on the cleared instance; called at a negedge.
    task automatic cyc(input logic en, input logic [3:0] a0, input logic [3:0] we,
                       input logic [3:0] a1, input logic [31:0] di,
                       input logic ck, input logic [31:0] ex);
        EN0 = en; A0 = a0; WE1 = we; A1 = a1; Di1 = di; chk_req = ck;
        if (ck) begin
            exp_q.push_back(ex);
            id_q.push_back(rd_id);
            rd_id++;
        end
        @(negedge CLK);
    endtask

    // Counts negedges with RDY low, starting at the negedge RST dropped.
    task automatic wait_rdy(output int n, output int leak);
        n = 0;
        leak = 0;
        while (!RDY && n < 100) begin
            if (Do0 !== 32'h0) leak++;
            n++;
            @(negedge CLK);
        end
        WE1 = '0;
        EN0 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n, leak;

        // Ports hammer word 0 with ones during every fill; none may land.
        WE1 = 4'hF; A1 = 4'h0; Di1 = 32'hFFFF_FFFF; EN0 = 1'b1; A0 = 4'h0;
        repeat (3) @(negedge CLK);
        chk("rst_rdy",  {31'b0, RDY},   32'h0);
        chk("rst_do0",  Do0,            32'h0);
        chk("rst_rdy0", {31'b0, RDY_0}, 32'h0);

        RST = 1'b0;
        wait_rdy(n, leak);
        chk("fill1_len",  n,    32'd16);
        chk("fill1_leak", leak, 32'd0);

        // Reset again, then cut the fill on its 8th cycle.
        RST = 1'b1; WE1 = 4'hF; EN0 = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        repeat (8) @(negedge CLK);
        chk("mid_rdy", {31'b0, RDY}, 32'h0);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        wait_rdy(n, leak);
        chk("fill2_len",  n,    32'd16);
        chk("fill2_leak", leak, 32'd0);

        // Every word reads back zero.
        for (int a = 0; a < 16; a++) begin
            logic [3:0] aa;
            aa = a[3:0];
            cyc(1'b1, aa, 4'h0, 4'h0, 32'h0, 1'b1, 32'h0);
        end

        // Full write then single-lane merge.
        cyc(1'b0, 4'h0, 4'hF, 4'h3, 32'hDEAD_BEEF, 1'b0, 32'h0);
        cyc(1'b0, 4'h0, 4'h2, 4'h3, 32'h0000_AA00, 1'b0, 32'h0);
        cyc(1'b1, 4'h3, 4'h0, 4'h0, 32'h0, 1'b1, 32'hDEAD_AAEF);
        // WE1=0 is a no-op even with data present.
        cyc(1'b0, 4'h0, 4'h0, 4'h3, 32'hFFFF_FFFF, 1'b0, 32'h0);
        // Independent read of word 3 alongside a write to word 7, then EN0=0.
        cyc(1'b1, 4'h3, 4'hF, 4'h7, 32'h1234_5678, 1'b1, 32'hDEAD_AAEF);
        cyc(1'b0, 4'h7, 4'h0, 4'h0, 32'h0, 1'b1, 32'h0);
        cyc(1'b1, 4'h7, 4'h0, 4'h0, 32'h0, 1'b1, 32'h1234_5678);

        // Collision, write-first per lane.
        cyc(1'b0, 4'h0, 4'hF, 4'h5, 32'h1122_3344, 1'b0, 32'h0);
        cyc(1'b1, 4'h5, 4'b1001, 4'h5, 32'hAA00_00BB, 1'b1, 32'hAA22_33BB);
        cyc(1'b1, 4'h5, 4'h0, 4'h0, 32'h0, 1'b1, 32'hAA22_33BB);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b1, 32'h0);
        cyc(1'b0, 4'h0, 4'h0, 4'h0, 32'h0, 1'b0, 32'h0);

        repeat (LAT + 1) @(negedge CLK);
        chk("sb_drain", exp_q.size(), 32'd0);

        // No-fill instance: ready on the first edge after reset drops.
        RST_0 = 1'b0;
        chk("nf_rdy_lo", {31'b0, RDY_0}, 32'h0);
        @(negedge CLK);
        chk("nf_rdy_hi", {31'b0, RDY_0}, 32'h1);
        WE1_0 = 4'hF; A1_0 = 4'hF; Di1_0 = 32'hCAFE_F00D;
        @(negedge CLK);
        WE1_0 = 4'h0; EN0_0 = 1'b1; A0_0 = 4'hF;
        @(negedge CLK);
        EN0_0 = 1'b0;
        repeat (LAT - 1) @(negedge CLK);
        chk("nf_rd15", Do0_0, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
